// File: rtl/retire_trace_pkg.sv
// Shared record format, type codes and summary ids for the retire trace producer.
// Cache summary ids exist only when RETIRE_TRACE_CACHE_STATS_EN is defined.
package retire_trace_pkg;

    localparam int REC_W    = 37;
    localparam int TYPE_LSB = 35;
    localparam int TAG_LSB  = 32;
    localparam int A_LSB    = 16;
    localparam int B_LSB    = 0;

    typedef enum logic [1:0] {
        REC_REG   = 2'b00,
        REC_LOAD  = 2'b01,
        REC_STORE = 2'b10,
        REC_SUM   = 2'b11
    } rec_type_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SUM,
        ST_DONE
    } state_e;

    localparam logic [2:0] SUM_CYC  = 3'd0;
    localparam logic [2:0] SUM_INST = 3'd1;
    localparam logic [2:0] SUM_DROP = 3'd2;
`ifdef RETIRE_TRACE_CACHE_STATS_EN
    localparam logic [2:0] SUM_IC_HIT = 3'd3;
    localparam logic [2:0] SUM_IC_REQ = 3'd4;
    localparam logic [2:0] SUM_DC_HIT = 3'd5;
    localparam logic [2:0] SUM_DC_REQ = 3'd6;
    localparam logic [2:0] SUM_LAST   = SUM_DC_REQ;
`else
    localparam logic [2:0] SUM_LAST   = SUM_DROP;
`endif

    function automatic logic [REC_W-1:0] pack_rec(input rec_type_e t, input logic [2:0] tag,
                                                  input logic [15:0] a, input logic [15:0] b);
        logic [REC_W-1:0] r;
        r                = '0;
        r[TYPE_LSB +: 2] = t;
        r[TAG_LSB +: 3]  = tag;
        r[A_LSB +: 16]   = a;
        r[B_LSB +: 16]   = b;
        return r;
    endfunction

endpackage

// File: rtl/retire_trace_tx_if.sv
// Valid/ready record stream from the retire trace producer to its sink.
interface retire_trace_tx_if;
    logic                              tr_valid;
    logic                              tr_ready;
    logic [retire_trace_pkg::REC_W-1:0] tr_data;

    modport master (output tr_valid, output tr_data, input tr_ready);
    modport slave  (input tr_valid, input tr_data, output tr_ready);
endinterface

// File: rtl/trace_fifo2w.sv
// Record FIFO with two write lanes and one registered read port.
// The output register counts as one of the DEPTH slots, so free covers the whole pipeline.
module trace_fifo2w import retire_trace_pkg::*; #(
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       wr_cnt,
    input  logic [REC_W-1:0] wr_data0,
    input  logic [REC_W-1:0] wr_data1,
    input  logic             rd_ready,
    output logic             out_valid,
    output logic [REC_W-1:0] out_data,
    output logic [CW-1:0]    free,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr1;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [REC_W-1:0] out_data_q, out_data_d;
    logic             pop;

    always_comb begin
        pop         = (count_q != '0) && (!out_valid_q || rd_ready);
        wr_ptr1     = wr_ptr_q + AW'(1);
        wr_ptr_d    = wr_ptr_q + AW'(wr_cnt);
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(wr_cnt) - CW'(pop);
        out_valid_d = pop ? 1'b1 : (rd_ready ? 1'b0 : out_valid_q);
        out_data_d  = pop ? mem[rd_ptr_q] : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_cnt != 2'd0) mem[wr_ptr_q] <= wr_data0;
        if (wr_cnt == 2'd2) mem[wr_ptr1]  <= wr_data1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign free      = CW'(DEPTH) - count_q - CW'(out_valid_q);
    assign empty     = (count_q == '0) && !out_valid_q;

endmodule

// File: rtl/retire_trace_tx.sv
// Retire trace producer: packs commit events into records, then streams summary counters after halt.
// Define RETIRE_TRACE_CACHE_STATS_EN to add the cache hit/request counters to the summary.
module retire_trace_tx import retire_trace_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_wr,
    input  logic [2:0]        reg_sel,
    input  logic [15:0]       reg_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              halt,
    input  logic              ic_req,
    input  logic              ic_hit,
    input  logic              dc_req,
    input  logic              dc_hit,
    retire_trace_tx_if.master tr,
    output logic              overflow,
    output logic              done
);
    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       sum_id_q, sum_id_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, inst_q, inst_d, drop_q, drop_d;
`ifdef RETIRE_TRACE_CACHE_STATS_EN
    logic [CNT_W-1:0] ic_hit_q, ic_hit_d, ic_req_q, ic_req_d;
    logic [CNT_W-1:0] dc_hit_q, dc_hit_d, dc_req_q, dc_req_d;
`else
    logic             unused_cache;
    assign unused_cache = &{1'b0, ic_req, ic_hit, dc_req, dc_hit};
`endif

    logic [REC_W-1:0] mem_rec, rec0, rec1, fifo_data, sum_rec;
    logic [1:0]       need, wr_cnt;
    logic             run, fits, drop, fifo_valid, fifo_empty, fifo_rd_ready, in_sum;
    logic [CW-1:0]    fifo_free;
    logic [CNT_W-1:0] sum_cnt;
    logic [31:0]      sum_val;

    // The REG record always leads; a simultaneous load+store keeps only the store.
    always_comb begin
        run     = (state_q == ST_RUN);
        mem_rec = mem_wr ? pack_rec(REC_STORE, 3'd0, mem_addr, mem_wdata)
                         : pack_rec(REC_LOAD, 3'd0, mem_addr, mem_rdata);
        rec0    = reg_wr ? pack_rec(REC_REG, reg_sel, 16'h0000, reg_data) : mem_rec;
        rec1    = mem_rec;
        need    = 2'(reg_wr) + 2'(mem_rd | mem_wr);
        fits    = (CW'(need) <= fifo_free);
        wr_cnt  = (run && fits) ? need : 2'd0;
        drop    = run && (need != 2'd0) && !fits;
    end

    always_comb begin
        overflow_d = overflow_q | drop;
        drop_d     = sat_inc(drop_q, drop);
        cyc_d      = sat_inc(cyc_q, run);
        inst_d     = sat_inc(inst_q, run && (halt || reg_wr || mem_wr));
`ifdef RETIRE_TRACE_CACHE_STATS_EN
        ic_hit_d   = sat_inc(ic_hit_q, run && ic_hit);
        ic_req_d   = sat_inc(ic_req_q, run && ic_req);
        dc_hit_d   = sat_inc(dc_hit_q, run && dc_hit);
        dc_req_d   = sat_inc(dc_req_q, run && dc_req);
`endif
    end

    always_comb begin
        state_d  = state_q;
        sum_id_d = sum_id_q;
        case (state_q)
            ST_RUN:   if (halt) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) begin
                state_d  = ST_SUM;
                sum_id_d = SUM_CYC;
            end
            ST_SUM:   if (tr.tr_ready) begin
                if (sum_id_q == SUM_LAST) state_d = ST_DONE;
                else                      sum_id_d = sum_id_q + 3'd1;
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        sum_cnt = '0;
        case (sum_id_q)
            SUM_CYC:    sum_cnt = cyc_q;
            SUM_INST:   sum_cnt = inst_q;
            SUM_DROP:   sum_cnt = drop_q;
`ifdef RETIRE_TRACE_CACHE_STATS_EN
            SUM_IC_HIT: sum_cnt = ic_hit_q;
            SUM_IC_REQ: sum_cnt = ic_req_q;
            SUM_DC_HIT: sum_cnt = dc_hit_q;
            SUM_DC_REQ: sum_cnt = dc_req_q;
`endif
            default:    sum_cnt = '0;
        endcase
        sum_val = 32'(sum_cnt);
        sum_rec = pack_rec(REC_SUM, sum_id_q, sum_val[31:16], sum_val[15:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            sum_id_q   <= SUM_CYC;
            overflow_q <= 1'b0;
            cyc_q      <= '0;
            inst_q     <= '0;
            drop_q     <= '0;
`ifdef RETIRE_TRACE_CACHE_STATS_EN
            ic_hit_q   <= '0;
            ic_req_q   <= '0;
            dc_hit_q   <= '0;
            dc_req_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sum_id_q   <= sum_id_d;
            overflow_q <= overflow_d;
            cyc_q      <= cyc_d;
            inst_q     <= inst_d;
            drop_q     <= drop_d;
`ifdef RETIRE_TRACE_CACHE_STATS_EN
            ic_hit_q   <= ic_hit_d;
            ic_req_q   <= ic_req_d;
            dc_hit_q   <= dc_hit_d;
            dc_req_q   <= dc_req_d;
`endif
        end
    end

    trace_fifo2w #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_cnt    (wr_cnt),
        .wr_data0  (rec0),
        .wr_data1  (rec1),
        .rd_ready  (fifo_rd_ready),
        .out_valid (fifo_valid),
        .out_data  (fifo_data),
        .free      (fifo_free),
        .empty     (fifo_empty)
    );

    // The summary only starts once the FIFO is empty, so the two sources never compete.
    assign in_sum        = (state_q == ST_SUM);
    assign fifo_rd_ready = tr.tr_ready && !in_sum;
    assign tr.tr_valid   = in_sum || fifo_valid;
    assign tr.tr_data    = in_sum ? sum_rec : fifo_data;
    assign overflow      = overflow_q;
    assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_retire_trace_tx.sv
// Directed bench for retire_trace_tx with a scoreboard of expected stream records.
module tb_retire_trace_tx;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr, mem_rd, mem_wr, halt;
    logic [2:0]  reg_sel;
    logic [15:0] reg_data, mem_addr, mem_wdata, mem_rdata;
    logic        ic_req, ic_hit, dc_req, dc_hit;
    logic        overflow, done;

    retire_trace_tx_if tr_if();

    retire_trace_tx #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_wr    (reg_wr),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .halt      (halt),
        .ic_req    (ic_req),
        .ic_hit    (ic_hit),
        .dc_req    (dc_req),
        .dc_hit    (dc_hit),
        .tr        (tr_if),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [36:0] q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_xfer = 0;
    bit          running = 1'b0;
    int unsigned cyc_m, inst_m, drop_m, ich_m, icr_m, dch_m, dcr_m;

    function automatic logic [36:0] rec(input logic [1:0] t, input logic [2:0] g,
                                        input logic [15:0] a, input logic [15:0] b);
        return {t, g, a, b};
    endfunction

    function automatic logic [36:0] srec(input logic [2:0] id, input logic [31:0] v);
        return {2'b11, id, v};
    endfunction

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reg_wr = 0; reg_sel = 0; reg_data = 0;
        mem_rd = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
        halt = 0; ic_req = 0; ic_hit = 0; dc_req = 0; dc_hit = 0;
    endtask

    // One clock: model the inputs driven now, then score any transfer at the edge.
    task automatic tick();
        logic        v, r;
        logic [36:0] d, e, mrec;
        int          need;
        if (running) begin
            need = int'(reg_wr) + int'(mem_rd | mem_wr);
            mrec = mem_wr ? rec(2'b10, 3'd0, mem_addr, mem_wdata)
                          : rec(2'b01, 3'd0, mem_addr, mem_rdata);
            if (need > 0) begin
                if (q.size() + need <= DEPTH) begin
                    if (reg_wr) q.push_back(rec(2'b00, reg_sel, 16'h0000, reg_data));
                    if (mem_rd | mem_wr) q.push_back(mrec);
                end else begin
                    drop_m++;
                end
            end
            cyc_m++;
            if (halt | reg_wr | mem_wr) inst_m++;
            if (ic_hit) ich_m++;
            if (ic_req) icr_m++;
            if (dc_hit) dch_m++;
            if (dc_req) dcr_m++;
            if (halt) begin
                running = 1'b0;
                q.push_back(srec(3'd0, cyc_m));
                q.push_back(srec(3'd1, inst_m));
                q.push_back(srec(3'd2, drop_m));
`ifdef RETIRE_TRACE_CACHE_STATS_EN
                q.push_back(srec(3'd3, ich_m));
                q.push_back(srec(3'd4, icr_m));
                q.push_back(srec(3'd5, dch_m));
                q.push_back(srec(3'd6, dcr_m));
`endif
            end
        end
        v = tr_if.tr_valid;
        r = tr_if.tr_ready;
        d = tr_if.tr_data;
        @(posedge clk);
        #1;
        clear_inputs();
        if (v && r) begin
            n_xfer++;
            $display("xfer %0d: type=%0d tag=%0d a=%h b=%h", n_xfer, d[36:35], d[34:32], d[31:16], d[15:0]);
            if (q.size() == 0) begin
                chk("stream_unexpected", d, 37'h0);
            end else begin
                e = q.pop_front();
                chk("stream", d, e);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tr_if.tr_ready = 1'b0;
        q.delete();
        running = 1'b0;
        cyc_m = 0; inst_m = 0; drop_m = 0; ich_m = 0; icr_m = 0; dch_m = 0; dcr_m = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 37'(tr_if.tr_valid), 37'h0);
        chk("rst_data", tr_if.tr_data, 37'h0);
        chk("rst_overflow", 37'(overflow), 37'h0);
        chk("rst_done", 37'(done), 37'h0);
        @(negedge clk);
        rst_n = 1'b1;
        running = 1'b1;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && q.size() != 0; i++) tick();
        chk("drain_empty", 37'(q.size()), 37'h0);
    endtask

    // Commit inputs keep toggling here to show they are ignored once halted.
    task automatic wait_done(input int max);
        for (int i = 0; i < max && !(done === 1'b1 && q.size() == 0); i++) begin
            reg_wr = 1'b1; reg_sel = 3'd7; reg_data = 16'hDEAD; mem_wr = 1'b1;
            tick();
        end
        chk("done_flag", 37'(done), 37'h1);
        chk("done_valid", 37'(tr_if.tr_valid), 37'h0);
        chk("done_queue", 37'(q.size()), 37'h0);
        repeat (3) tick();
        chk("done_hold", 37'({done, tr_if.tr_valid}), 37'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [36:0] prev;
        clear_inputs();
        tr_if.tr_ready = 1'b0;

        // Run A: record formats, back-to-back, stall/overflow, cache stats, summary.
        do_reset();
        tr_if.tr_ready = 1'b1;

        reg_wr = 1; reg_sel = 3'd3; reg_data = 16'h1234;
        tick();
        chk("t1_latency", 37'(tr_if.tr_valid), 37'h0);
        tick();
        chk("t1_valid", 37'(tr_if.tr_valid), 37'h1);
        chk("t1_data", tr_if.tr_data, rec(2'b00, 3'd3, 16'h0000, 16'h1234));
        drain(5);

        reg_wr = 1; reg_sel = 3'd2; reg_data = 16'hBEEF;
        mem_rd = 1; mem_addr = 16'h0040; mem_rdata = 16'hBEEF;
        tick();
        repeat (3) tick();
        chk("t2_back_to_back", 37'(q.size()), 37'h0);

        mem_rd = 1; mem_wr = 1; mem_addr = 16'h0080; mem_wdata = 16'h5555; mem_rdata = 16'hAAAA;
        tick();
        drain(5);
        chk("t2_no_overflow", 37'(overflow), 37'h0);

        tr_if.tr_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            mem_wr = 1; mem_addr = 16'h0100 + 16'(i); mem_wdata = 16'(i);
            tick();
        end
        chk("t3_overflow", 37'(overflow), 37'h1);
        chk("t3_retained", 37'(q.size()), 37'(DEPTH));
        chk("t3_head", tr_if.tr_data, rec(2'b10, 3'd0, 16'h0100, 16'h0000));
        prev = tr_if.tr_data;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_hold", tr_if.tr_data, prev);
        end
        tr_if.tr_ready = 1'b1;
        drain(3 * DEPTH);

        ic_req = 1; ic_hit = 1; tick();
        ic_req = 1; ic_hit = 1; dc_req = 1; tick();
        ic_req = 1; tick();
        dc_req = 1; dc_hit = 1; reg_wr = 1; reg_sel = 3'd1; reg_data = 16'h0A0A; tick();
        reg_wr = 1; reg_sel = 3'd5; reg_data = 16'h0F0F; halt = 1; tick();
        wait_done(200);

        // Run B: exact counts, then reset in the middle of the summary.
        do_reset();
        tr_if.tr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0 && i < 8) begin
                reg_wr = 1; reg_sel = 3'(i); reg_data = 16'h0100 + 16'(i);
            end
            tick();
        end
        halt = 1;
        tick();
        for (int i = 0; i < 40 && !(tr_if.tr_valid === 1'b1 && tr_if.tr_data[36:35] === 2'b11); i++) tick();
        chk("t4_id0", tr_if.tr_data, srec(3'd0, 32'd11));
        tick();
        chk("t4_id1", tr_if.tr_data, srec(3'd1, 32'd5));
        tr_if.tr_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_now", 37'(tr_if.tr_valid), 37'h0);
        chk("t6_done_now", 37'(done), 37'h0);
        do_reset();
        tr_if.tr_ready = 1'b1;
        halt = 1;
        tick();
        for (int i = 0; i < 20 && !(tr_if.tr_valid === 1'b1 && tr_if.tr_data[36:35] === 2'b11); i++) tick();
        chk("t6_fresh_cyc", tr_if.tr_data, srec(3'd0, 32'd1));
        wait_done(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
